// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for both sides of the asynchronous FIFO.
//   ADDR_W_DEF : default RAM address width
//   PTR_W      : pointer width (one extra wrap bit above the address)
//   bin2gray   : binary to reflected Gray code
//   gray2bin   : reflected Gray code to binary
// Both conversions work on a zero-extended 32-bit word, so a caller of any
// width up to 32 bits converts by extending its value in and truncating the
// result back to its own width.
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int PTR_W      = ADDR_W_DEF + 1;
  localparam int CONV_W     = 32;

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of its own Gray bit and every Gray bit above
  // it. Zero upper bits add nothing, so this holds for any narrower width.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b = '0;
    for (int i = 0; i < CONV_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ctrl_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a multi-bit Gray-coded bus. Only one bit of the
// bus changes per source update, so per-bit synchronization is safe.
//   clk   : destination-domain clock
//   rst_n : synchronous active-low reset, clears both stages
//   d     : asynchronous input bus
//   q1    : first-stage flop (possibly metastable, exposed for observation)
//   q     : second-stage flop, safe to use in the destination domain
module sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/rd_ctrl.sv
// rd_ctrl
// Read-side controller of the asynchronous FIFO, entirely in the rclk domain.
// Owns the binary/Gray read pointer, brings the write pointer across with a
// two-flop synchronizer, and produces registered empty, almost-empty and
// level flags, the RAM read address and registered read data.
//   rclk          : read clock
//   rrst_n        : synchronous active-low reset
//   rinc          : read request from the consumer
//   wptr          : Gray write pointer from the write domain (asynchronous)
//   rmem_data     : RAM read data, combinational from raddr
//   rptr          : registered Gray read pointer, to the write domain
//   raddr         : RAM read address (low bits of the binary read pointer)
//   rdata         : registered read data
//   rvalid        : one-cycle pulse qualifying rdata
//   rempty        : registered empty flag
//   ralmost_empty : registered, high when rlevel <= AE_THRESH
//   rlevel        : registered occupancy as seen by the read side
//   runderflow    : sticky, set by a read request while empty
module rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = 32,
  parameter int AE_THRESH  = 2
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   wptr,
  input  logic [DATA_WIDTH-1:0] rmem_data,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  runderflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wq1;
  logic [PW-1:0] wq2;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] level_next;
  logic          rd_en;

  // ---- stage: write pointer crossing (wq1 -> wq2) ----
  sync_2ff #(
    .WIDTH (PW)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr),
    .q1    (wq1),
    .q     (wq2)
  );

  // ---- stage: next-pointer and flag arithmetic (combinational) ----
  // A request while empty is ignored here and only recorded as underflow.
  assign rd_en      = rinc & ~rempty;
  assign rbin_next  = rbin + PW'(rd_en);
  assign rgray_next = PW'(bin2gray(CONV_W'(rbin_next)));
  assign wbin_s     = PW'(gray2bin(CONV_W'(wq2)));
  // Modulo-2^PW subtraction; the wrap bit makes a full FIFO read as 2^ADDR.
  assign level_next = wbin_s - rbin_next;

  assign raddr = rbin[ADDR_WIDTH-1:0];

  // ---- stage: registered pointer, flags and read data ----
  // Flags use the post-read pointer, so the read that drains the last word
  // raises rempty on the same edge and blocks the next request.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rdata         <= '0;
      rvalid        <= 1'b0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      runderflow    <= 1'b0;
    end else begin
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == wq2);
      rlevel        <= level_next;
      ralmost_empty <= (level_next <= AE_T);
      rvalid        <= rd_en;
      runderflow    <= runderflow | (rinc & rempty);
      if (rd_en) begin
        rdata <= rmem_data;
      end
    end
  end

endmodule
